softmax_stable: RTL and testbench
=================================

# softmax_stable

Numerically stable, stream-handshaked softmax for the attention stage: alpha_i = 2^(c_i − max) / Σ 2^(c_j − max) over each subgraph's signed coefficients. It sits between the DMVM coefficient stream and the aggregator alpha stream. Each subgraph's coefficients are buffered internally so the maximum can be subtracted. One reciprocal of the sum is computed per subgraph, and every alpha is then produced by a shift.

## Interface
- DATA_WIDTH, 8, coefficient width (signed two's complement)
- ALPHA_DATA_WIDTH, 32, alpha width; format Q1.(ALPHA_DATA_WIDTH−1), WOF = ALPHA_DATA_WIDTH−1
- EXP_FRAC, 24, fractional bits of each 2^(c−max) term
- MAX_NODES, 168, maximum nodes per subgraph (buffer depth)
- Derived: NN_W = $clog2(MAX_NODES+1); SUM_W = EXP_FRAC + 1 + $clog2(MAX_NODES)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- num_node_i  in  NN_W  node count of the next subgraph
- num_node_vld_i / num_node_rdy_o  in/out  1  count handshake
- coef_i  in  DATA_WIDTH  signed coefficient
- coef_vld_i / coef_rdy_o  in/out  1  coefficient handshake
- alpha_o  out  ALPHA_DATA_WIDTH  normalized coefficient
- alpha_vld_o / alpha_rdy_i  out/in  1  alpha handshake
- alpha_last_o  out  1  last alpha of subgraph (only with SOFTMAX_LAST_EN)
- busy_o  out  1  high in any state except IDLE

## Operation
- FSM states:
  - IDLE: num_node_rdy_o=1. On the handshake, latch N = min(num_node_i, MAX_NODES) and go to LOAD. If N=0, stay in IDLE (the count is consumed, no output).
  - LOAD: coef_rdy_o=1. Each accepted coef is written to buffer[k], k=0..N−1, and the running signed max is updated (the first coef initialises max). After the N-th accept, go to SUM.
  - SUM: N cycles, one buffer read per cycle. d = max − c (unsigned, DATA_WIDTH+1 bits). term = 2^(EXP_FRAC−d) if d ≤ EXP_FRAC, else 0. sum += term, in SUM_W bits, which cannot overflow.
  - DIV: restoring divider, exactly ALPHA_DATA_WIDTH cycles. R = floor(2^(WOF+EXP_FRAC) / sum). sum ≥ 2^EXP_FRAC always, so R ≤ 2^WOF and fits.
  - EMIT: for k=0..N−1, alpha_o = (d_k ≥ ALPHA_DATA_WIDTH) ? 0 : R >> d_k. d_k is recomputed from buffer[k]. After the N-th accepted beat, go to IDLE.
- Handshakes use standard vld/rdy; a transfer occurs on the cycle where both are high.
- alpha_o and alpha_vld_o are registered. While alpha_vld_o=1 and alpha_rdy_i=0, alpha_o holds stable.
- num_node_i, coef_i and alpha_rdy_i are ignored in states where the matching rdy is low.
- Output order equals input coefficient order.

## Timing
- Reset values: num_node_rdy_o=1, coef_rdy_o=0, alpha_vld_o=0, alpha_o=0, alpha_last_o=0, busy_o=0, FSM=IDLE.
- Count handshake at cycle T → coef_rdy_o=1 from T+1.
- Last coef accepted at cycle L → SUM occupies L+1..L+N, DIV occupies L+N+1..L+N+ALPHA_DATA_WIDTH, first alpha_vld_o=1 at L+N+ALPHA_DATA_WIDTH+1.
- With alpha_rdy_i held high, one alpha is emitted per cycle.
- After the last alpha is accepted at cycle E, num_node_rdy_o=1 at E+1.
- Processing is not overlapped: the next subgraph is not accepted until the current one is fully emitted.
- Reset asserted in any state: returns to IDLE immediately, discards buffer/max/sum/R, and forces all outputs to their reset values. No partial subgraph resumes.
- Gaps in coef_vld_i during LOAD stall the FSM without loss.

## Configuration
- SOFTMAX_LAST_EN defined: alpha_last_o exists. It is 1 exactly with the beat for k=N−1 and 0 otherwise; it is registered alongside alpha_o.
- SOFTMAX_LAST_EN undefined: the alpha_last_o port and its logic are absent. All other behaviour is identical.

## Test plan
- N=1, coef=5 → one beat alpha_o=0x80000000. First valid at 1+1+32 cycles after the coef accept.
- N=2, coefs 7,7 → 0x40000000, 0x40000000.
- N=2, coefs 3,2 → sum=3·2^23, R=0x55555555 → alphas 0x55555555, 0x2AAAAAAA.
- N=2, coefs −128,127 → d=255 then 0 → alphas 0x00000000, 0x80000000. alpha_last_o=1 on the second beat only (with SOFTMAX_LAST_EN).
- N=3 with alpha_rdy_i toggling 0/1 each cycle → alpha_o stable during stalls, 3 beats total. num_node_rdy_o rises the cycle after the 3rd accept.
- num_node_i=0 → no alpha beats and busy_o stays 0. Separately, assert rst mid-EMIT of N=4 → next cycle alpha_vld_o=0 and num_node_rdy_o=1; a fresh N=1, coef=0 then yields 0x80000000.

Source files
------------

// File: rtl/softmax_stable.sv
// Numerically stable streaming softmax: buffers a subgraph, finds its max, sums 2^(c-max),
// divides once, then emits each alpha as a shift of the reciprocal. Optional alpha_last_o via SOFTMAX_LAST_EN.
module softmax_stable #(
  parameter int DATA_WIDTH       = 8,
  parameter int ALPHA_DATA_WIDTH = 32,
  parameter int EXP_FRAC         = 24,
  parameter int MAX_NODES        = 168,
  localparam int NN_W            = $clog2(MAX_NODES + 1),
  localparam int SUM_W           = EXP_FRAC + 1 + $clog2(MAX_NODES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NN_W-1:0]                num_node_i,
  input  logic                           num_node_vld_i,
  output logic                           num_node_rdy_o,
  input  logic signed [DATA_WIDTH-1:0]   coef_i,
  input  logic                           coef_vld_i,
  output logic                           coef_rdy_o,
  output logic [ALPHA_DATA_WIDTH-1:0]    alpha_o,
  output logic                           alpha_vld_o,
  input  logic                           alpha_rdy_i,
`ifdef SOFTMAX_LAST_EN
  output logic                           alpha_last_o,
`endif
  output logic                           busy_o
);

  localparam int AW  = $clog2(MAX_NODES);
  localparam int CW  = $clog2(ALPHA_DATA_WIDTH);
  localparam int ADW = ALPHA_DATA_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SUM, S_DIV, S_EMIT} state_t;

  state_t                        r_state;
  logic signed [DATA_WIDTH-1:0]  r_buf [MAX_NODES];
  logic signed [DATA_WIDTH-1:0]  r_max;
  logic [AW-1:0]                 r_k;
  logic [AW-1:0]                 r_last;
  logic [SUM_W-1:0]              r_sum;
  logic [SUM_W-1:0]              r_rem;
  logic [ADW-1:0]                r_q;
  logic [CW-1:0]                 r_cnt;
  logic                          r_num_node_rdy;
  logic                          r_coef_rdy;
  logic                          r_busy;
  logic [ADW-1:0]                r_alpha;
  logic                          r_alpha_vld;
`ifdef SOFTMAX_LAST_EN
  logic                          r_alpha_last;
`endif

  logic [NN_W-1:0]               w_n;
  logic [AW-1:0]                 w_rd_addr;
  logic signed [DATA_WIDTH-1:0]  w_rd_coef;
  logic [DATA_WIDTH:0]           w_d;
  logic [SUM_W-1:0]              w_term;
  logic signed [DATA_WIDTH-1:0]  w_new_max;
  logic [SUM_W:0]                w_rem_sh;
  logic                          w_q_bit;
  logic [SUM_W-1:0]              w_rem_nx;
  logic [ADW-1:0]                w_q_nx;
  logic [ADW-1:0]                w_alpha;
  logic [AW-1:0]                 w_k_nx;

  function automatic logic [ADW-1:0] shr_alpha(input logic [ADW-1:0] q,
                                               input logic [DATA_WIDTH:0] d);
    return (32'(d) >= 32'(ADW)) ? '0 : (q >> d);
  endfunction

  assign w_n    = (num_node_i > NN_W'(MAX_NODES)) ? NN_W'(MAX_NODES) : num_node_i;
  assign w_k_nx = AW'(r_k + 1'b1);

  // One shared buffer read port: SUM walks r_k, the last DIV cycle prefetches entry 0,
  // EMIT prefetches the entry after the beat currently on the output.
  always_comb begin
    w_rd_addr = r_k;
    case (r_state)
      S_DIV:   w_rd_addr = '0;
      S_EMIT:  w_rd_addr = (r_k == r_last) ? '0 : w_k_nx;
      default: w_rd_addr = r_k;
    endcase
  end

  assign w_rd_coef = r_buf[w_rd_addr];
  assign w_d       = {r_max[DATA_WIDTH-1], r_max} - {w_rd_coef[DATA_WIDTH-1], w_rd_coef};
  assign w_term    = (32'(w_d) <= 32'(EXP_FRAC))
                     ? (SUM_W'(1) << (32'(EXP_FRAC) - 32'(w_d))) : '0;
  assign w_new_max = (r_k == '0 || coef_i > r_max) ? coef_i : r_max;

  // Restoring divider: dividend 2^(WOF+EXP_FRAC) has only zeros below bit ADW, so the
  // remainder starts at its upper part 2^(EXP_FRAC-1) and one quotient bit is produced per cycle.
  assign w_rem_sh = {r_rem, 1'b0};
  assign w_q_bit  = (w_rem_sh >= {1'b0, r_sum});
  assign w_rem_nx = w_q_bit ? SUM_W'(w_rem_sh - {1'b0, r_sum}) : w_rem_sh[SUM_W-1:0];
  assign w_q_nx   = {r_q[ADW-2:0], w_q_bit};
  assign w_alpha  = shr_alpha((r_state == S_DIV) ? w_q_nx : r_q, w_d);

  always_ff @(posedge clk) begin
    if (r_coef_rdy && coef_vld_i) r_buf[r_k] <= coef_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_max          <= '0;
      r_k            <= '0;
      r_last         <= '0;
      r_sum          <= '0;
      r_rem          <= '0;
      r_q            <= '0;
      r_cnt          <= '0;
      r_num_node_rdy <= 1'b1;
      r_coef_rdy     <= 1'b0;
      r_busy         <= 1'b0;
      r_alpha        <= '0;
      r_alpha_vld    <= 1'b0;
`ifdef SOFTMAX_LAST_EN
      r_alpha_last   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (num_node_vld_i && w_n != '0) begin
            r_last         <= AW'(w_n - 1'b1);
            r_k            <= '0;
            r_state        <= S_LOAD;
            r_num_node_rdy <= 1'b0;
            r_coef_rdy     <= 1'b1;
            r_busy         <= 1'b1;
          end
        end
        S_LOAD: begin
          if (coef_vld_i) begin
            r_max <= w_new_max;
            if (r_k == r_last) begin
              r_state    <= S_SUM;
              r_coef_rdy <= 1'b0;
              r_k        <= '0;
              r_sum      <= '0;
            end else begin
              r_k <= w_k_nx;
            end
          end
        end
        S_SUM: begin
          r_sum <= r_sum + w_term;
          if (r_k == r_last) begin
            r_state <= S_DIV;
            r_k     <= '0;
            r_rem   <= SUM_W'(1) << (EXP_FRAC - 1);
            r_q     <= '0;
            r_cnt   <= '0;
          end else begin
            r_k <= w_k_nx;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nx;
          r_q   <= w_q_nx;
          r_cnt <= CW'(r_cnt + 1'b1);
          if (r_cnt == CW'(ADW - 1)) begin
            r_state      <= S_EMIT;
            r_alpha      <= w_alpha;
            r_alpha_vld  <= 1'b1;
`ifdef SOFTMAX_LAST_EN
            r_alpha_last <= (r_last == '0);
`endif
          end
        end
        S_EMIT: begin
          if (alpha_rdy_i) begin
            if (r_k == r_last) begin
              r_state        <= S_IDLE;
              r_alpha        <= '0;
              r_alpha_vld    <= 1'b0;
              r_num_node_rdy <= 1'b1;
              r_busy         <= 1'b0;
`ifdef SOFTMAX_LAST_EN
              r_alpha_last   <= 1'b0;
`endif
            end else begin
              r_k          <= w_k_nx;
              r_alpha      <= w_alpha;
`ifdef SOFTMAX_LAST_EN
              r_alpha_last <= (w_k_nx == r_last);
`endif
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign num_node_rdy_o = r_num_node_rdy;
  assign coef_rdy_o     = r_coef_rdy;
  assign alpha_o        = r_alpha;
  assign alpha_vld_o    = r_alpha_vld;
  assign busy_o         = r_busy;
`ifdef SOFTMAX_LAST_EN
  assign alpha_last_o   = r_alpha_last;
`endif

endmodule

// File: tb/tb_softmax_stable.sv
// Directed + randomized bench for softmax_stable; expected alphas come from a plain-arithmetic
// softmax reference or hand-derived constants.
module tb_softmax_stable;

  localparam int ADW    = 32;
  localparam int EF     = 24;
  localparam int NN_W   = 8;
  localparam int BUDGET = 5000;

  logic              clk = 1'b0;
  logic              rst;
  logic [NN_W-1:0]   num_node_i;
  logic              num_node_vld;
  logic              num_node_rdy;
  logic signed [7:0] coef_i;
  logic              coef_vld;
  logic              coef_rdy;
  logic [31:0]       alpha;
  logic              alpha_vld;
  logic              alpha_rdy;
  logic              busy;
`ifdef SOFTMAX_LAST_EN
  logic              alpha_last;
`endif

  softmax_stable #(.DATA_WIDTH(8), .ALPHA_DATA_WIDTH(ADW), .EXP_FRAC(EF), .MAX_NODES(168)) dut (
    .clk            (clk),
    .rst            (rst),
    .num_node_i     (num_node_i),
    .num_node_vld_i (num_node_vld),
    .num_node_rdy_o (num_node_rdy),
    .coef_i         (coef_i),
    .coef_vld_i     (coef_vld),
    .coef_rdy_o     (coef_rdy),
    .alpha_o        (alpha),
    .alpha_vld_o    (alpha_vld),
    .alpha_rdy_i    (alpha_rdy),
`ifdef SOFTMAX_LAST_EN
    .alpha_last_o   (alpha_last),
`endif
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [7:0] q_coef[$];
  logic [31:0]       q_exp[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference softmax: alpha_i = floor(2^(31+24)/sum) >> (max - c_i)
  function automatic void build_model();
    int mx = int'(q_coef[0]);
    longint unsigned sum = 0;
    longint unsigned r;
    foreach (q_coef[i]) if (int'(q_coef[i]) > mx) mx = int'(q_coef[i]);
    foreach (q_coef[i]) begin
      int d = mx - int'(q_coef[i]);
      if (d <= EF) sum += 64'd1 << (EF - d);
    end
    r = (64'd1 << (ADW - 1 + EF)) / sum;
    q_exp.delete();
    foreach (q_coef[i]) begin
      int d = mx - int'(q_coef[i]);
      q_exp.push_back((d >= ADW) ? 32'd0 : 32'(r >> d));
    end
  endfunction

  task automatic fill_random(input int n, input int lo, input int hi);
    q_coef.delete();
    for (int i = 0; i < n; i++) q_coef.push_back(8'($urandom_range(hi - lo) + lo));
  endtask

  task automatic send_count(input int n);
    int t = 0;
    @(negedge clk);
    num_node_i   = NN_W'(n);
    num_node_vld = 1'b1;
    while (!num_node_rdy && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    chk("count_rdy_in_budget", 64'(t < BUDGET), 64'd1);
    @(posedge clk);
    #1 num_node_vld = 1'b0;
  endtask

  task automatic send_coefs(input bit gaps, output int last_cyc);
    int idx = 0;
    int t = 0;
    last_cyc = 0;
    while (idx < q_coef.size() && t < BUDGET) begin
      @(negedge clk);
      t++;
      coef_i   = q_coef[idx];
      coef_vld = gaps ? 1'($urandom_range(1)) : 1'b1;
      if (coef_vld && coef_rdy) begin
        @(posedge clk);
        #1;
        idx++;
        last_cyc = cyc;
        coef_vld = 1'b0;
      end
    end
    coef_vld = 1'b0;
    chk("coefs_accepted", 64'(idx), 64'(q_coef.size()));
  endtask

  // mode 0: always ready, 1: toggling, 2: random
  task automatic recv(input int mode, input int l_cyc);
    int n = q_exp.size();
    int idx = 0;
    int t = 0;
    bit first = 1'b1;
    bit held_v = 1'b0;
    logic [31:0] held = '0;
    while (idx < n && t < BUDGET) begin
      @(negedge clk);
      t++;
      if (alpha_vld && first) begin
        chk("first_vld_latency", 64'(cyc - l_cyc), 64'(n + ADW));
        first = 1'b0;
      end
      if (held_v) begin
        chk("stall_vld_hold", 64'(alpha_vld), 64'd1);
        chk("stall_alpha_hold", 64'(alpha), 64'(held));
      end
      alpha_rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(t & 1) : 1'($urandom_range(1));
      held_v = 1'b0;
      if (alpha_vld) begin
        if (alpha_rdy) begin
          chk($sformatf("alpha%0d", idx), 64'(alpha), 64'(q_exp[idx]));
`ifdef SOFTMAX_LAST_EN
          chk($sformatf("last%0d", idx), 64'(alpha_last), 64'(idx == n - 1));
`endif
          idx++;
        end else begin
          held   = alpha;
          held_v = 1'b1;
        end
      end
    end
    chk("beats_received", 64'(idx), 64'(n));
    @(negedge clk);
    alpha_rdy = 1'b0;
    chk("num_node_rdy_after_last", 64'(num_node_rdy), 64'd1);
    chk("vld_low_after_last", 64'(alpha_vld), 64'd0);
    chk("busy_low_after_last", 64'(busy), 64'd0);
  endtask

  task automatic run_case(input int n_req, input bit gaps, input int mode);
    int l_cyc;
    send_count(n_req);
    send_coefs(gaps, l_cyc);
    recv(mode, l_cyc);
  endtask

  initial begin
    int l_cyc;
    int t;
    rst = 1'b1; num_node_i = '0; num_node_vld = 1'b0;
    coef_i = '0; coef_vld = 1'b0; alpha_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_num_node_rdy", 64'(num_node_rdy), 64'd1);
    chk("rst_coef_rdy", 64'(coef_rdy), 64'd0);
    chk("rst_alpha_vld", 64'(alpha_vld), 64'd0);
    chk("rst_alpha", 64'(alpha), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
`ifdef SOFTMAX_LAST_EN
    chk("rst_last", 64'(alpha_last), 64'd0);
`endif
    rst = 1'b0;

    q_coef = '{8'sd5};            q_exp = '{32'h80000000};
    run_case(1, 1'b0, 0);
    q_coef = '{8'sd7, 8'sd7};     q_exp = '{32'h40000000, 32'h40000000};
    run_case(2, 1'b0, 0);
    q_coef = '{8'sd3, 8'sd2};     q_exp = '{32'h55555555, 32'h2AAAAAAA};
    run_case(2, 1'b1, 0);
    q_coef = '{-8'sd128, 8'sd127}; q_exp = '{32'h00000000, 32'h80000000};
    run_case(2, 1'b0, 0);

    q_coef = '{8'sd1, 8'sd0, -8'sd1};
    build_model();
    run_case(3, 1'b0, 1);

    send_count(0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("n0_busy", 64'(busy), 64'd0);
      chk("n0_vld", 64'(alpha_vld), 64'd0);
      chk("n0_coef_rdy", 64'(coef_rdy), 64'd0);
    end

    fill_random(168, -20, 10);
    build_model();
    run_case(200, 1'b0, 2);

    for (int i = 0; i < 8; i++) begin
      int n = int'($urandom_range(24)) + 1;
      if (i < 4) fill_random(n, -128, 127);
      else       fill_random(n, -12, 12);
      build_model();
      run_case(n, 1'($urandom_range(1)), int'($urandom_range(2)));
    end

    fill_random(4, -5, 5);
    send_count(4);
    send_coefs(1'b0, l_cyc);
    t = 0;
    @(negedge clk);
    while (!alpha_vld && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    chk("rst_test_reached_emit", 64'(alpha_vld), 64'd1);
    alpha_rdy = 1'b1;
    @(negedge clk);
    alpha_rdy = 1'b0;
    rst = 1'b1;
    #1;
    chk("midemit_rst_vld", 64'(alpha_vld), 64'd0);
    chk("midemit_rst_rdy", 64'(num_node_rdy), 64'd1);
    @(negedge clk);
    chk("midemit_rst_busy", 64'(busy), 64'd0);
    chk("midemit_rst_alpha", 64'(alpha), 64'd0);
    rst = 1'b0;
    q_coef = '{8'sd0}; q_exp = '{32'h80000000};
    run_case(1, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
